sys_cmd_ctrl: RTL and testbench

Parametrised command-frame controller between the UART RX/TX path, register file, ALU and TX FIFO. It decodes command bytes with configurable opcodes and drives register-file write/read and ALU operand/function sequencing. Multi-byte ALU results and read data are returned through the FIFO with full backpressure on every byte. All outputs are registered; unknown opcodes are flagged; ALU clock gating applies only while a computation is pending.

---
 rtl/sys_cmd_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_sys_cmd_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_cmd_ctrl.sv
// Command-frame controller: decodes UART command bytes into register-file and ALU sequencing,
// and streams read data / ALU results into the TX FIFO. Optional inter-byte timeout: SYS_CMD_CTRL_TIMEOUT_EN.
module sys_cmd_ctrl #(
    parameter int                 D_WIDTH     = 8,
    parameter int                 ADDR_WIDTH  = 4,
    parameter int                 FUNC_WIDTH  = 4,
    parameter int                 ALU_BYTES   = 2,
    parameter logic [D_WIDTH-1:0] CMD_WR      = 8'hAA,
    parameter logic [D_WIDTH-1:0] CMD_RD      = 8'hBB,
    parameter logic [D_WIDTH-1:0] CMD_ALU_OP  = 8'hCC,
    parameter logic [D_WIDTH-1:0] CMD_ALU_NOP = 8'hDD,
    parameter int                 OP_A_ADDR   = 0,
    parameter int                 OP_B_ADDR   = 1,
    parameter int                 TIMEOUT_CYC = 1024
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [D_WIDTH-1:0]           RX_P_DATA,
    input  logic                         RX_D_VLD,
    input  logic [D_WIDTH-1:0]           RD_DATA,
    input  logic                         RD_DATA_VALID,
    input  logic [ALU_BYTES*D_WIDTH-1:0] ALU_OUT,
    input  logic                         OUT_VALID,
    input  logic                         FIFO_FULL,
    output logic                         WrEn,
    output logic                         RdEn,
    output logic [ADDR_WIDTH-1:0]        Address,
    output logic [D_WIDTH-1:0]           WrData,
    output logic                         ALU_EN,
    output logic [FUNC_WIDTH-1:0]        ALU_FUNC,
    output logic                         CLK_EN,
    output logic                         clk_div_en,
    output logic [D_WIDTH-1:0]           TX_P_DATA,
    output logic                         TX_D_VLD,
    output logic                         CMD_ERR
);

    localparam int RES_W = ALU_BYTES * D_WIDTH;
    localparam int CNT_W = $clog2(ALU_BYTES + 1);

    typedef enum logic [3:0] {
        IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT,
        ALU_A, ALU_B, ALU_FN, ALU_WAIT, TX_OUT
    } state_t;

    state_t                  state, state_d;
    logic [ADDR_WIDTH-1:0]   addr_lat, addr_lat_d;
    logic [RES_W-1:0]        tx_buf, tx_buf_d;
    logic [CNT_W-1:0]        tx_cnt, tx_cnt_d;
    logic                    wr_en_d, rd_en_d, alu_en_d, clk_en_d, tx_vld_d, cmd_err_d;
    logic [ADDR_WIDTH-1:0]   address_d;
    logic [D_WIDTH-1:0]      wr_data_d, tx_data_d;
    logic [FUNC_WIDTH-1:0]   alu_func_d;
    logic                    tmo_hit;

`ifdef SYS_CMD_CTRL_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_cnt;
    logic             waiting;

    assign waiting = (state inside {WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B, ALU_FN});
    assign tmo_hit = waiting && !RX_D_VLD && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

    // Counter restarts on every byte and whenever the frame state moves on.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            tmo_cnt <= '0;
        else if (!waiting || RX_D_VLD || tmo_hit)
            tmo_cnt <= '0;
        else
            tmo_cnt <= tmo_cnt + 1'b1;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d    = state;
        addr_lat_d = addr_lat;
        tx_buf_d   = tx_buf;
        tx_cnt_d   = tx_cnt;
        wr_en_d    = 1'b0;
        rd_en_d    = 1'b0;
        address_d  = Address;
        wr_data_d  = WrData;
        alu_en_d   = ALU_EN;
        alu_func_d = ALU_FUNC;
        tx_vld_d   = 1'b0;
        tx_data_d  = TX_P_DATA;
        cmd_err_d  = 1'b0;

        case (state)
            IDLE: if (RX_D_VLD) begin
                if (RX_P_DATA == CMD_WR)           state_d = WR_ADDR;
                else if (RX_P_DATA == CMD_RD)      state_d = RD_ADDR;
                else if (RX_P_DATA == CMD_ALU_OP)  state_d = ALU_A;
                else if (RX_P_DATA == CMD_ALU_NOP) state_d = ALU_FN;
                else                               cmd_err_d = 1'b1;
            end
            WR_ADDR: if (RX_D_VLD) begin
                addr_lat_d = RX_P_DATA[ADDR_WIDTH-1:0];
                state_d    = WR_DATA;
            end
            WR_DATA: if (RX_D_VLD) begin
                wr_en_d   = 1'b1;
                address_d = addr_lat;
                wr_data_d = RX_P_DATA;
                state_d   = IDLE;
            end
            RD_ADDR: if (RX_D_VLD) begin
                rd_en_d   = 1'b1;
                address_d = RX_P_DATA[ADDR_WIDTH-1:0];
                state_d   = RD_WAIT;
            end
            RD_WAIT: if (RD_DATA_VALID) begin
                tx_buf_d = RES_W'(RD_DATA);
                tx_cnt_d = CNT_W'(1);
                state_d  = TX_OUT;
            end
            ALU_A: if (RX_D_VLD) begin
                wr_en_d   = 1'b1;
                address_d = ADDR_WIDTH'(OP_A_ADDR);
                wr_data_d = RX_P_DATA;
                state_d   = ALU_B;
            end
            ALU_B: if (RX_D_VLD) begin
                wr_en_d   = 1'b1;
                address_d = ADDR_WIDTH'(OP_B_ADDR);
                wr_data_d = RX_P_DATA;
                state_d   = ALU_FN;
            end
            ALU_FN: if (RX_D_VLD) begin
                alu_func_d = RX_P_DATA[FUNC_WIDTH-1:0];
                alu_en_d   = 1'b1;
                state_d    = ALU_WAIT;
            end
            ALU_WAIT: if (OUT_VALID) begin
                tx_buf_d = ALU_OUT;
                tx_cnt_d = CNT_W'(ALU_BYTES);
                alu_en_d = 1'b0;
                state_d  = TX_OUT;
            end
            // LSB byte first; the buffer shifts down one byte per accepted write.
            TX_OUT: if (!FIFO_FULL) begin
                tx_vld_d  = 1'b1;
                tx_data_d = tx_buf[D_WIDTH-1:0];
                tx_buf_d  = tx_buf >> D_WIDTH;
                tx_cnt_d  = tx_cnt - 1'b1;
                if (tx_cnt == CNT_W'(1))
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (tmo_hit) begin
            state_d   = IDLE;
            cmd_err_d = 1'b1;
        end

        clk_en_d = (state_d == ALU_WAIT);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            addr_lat   <= '0;
            tx_buf     <= '0;
            tx_cnt     <= '0;
            WrEn       <= 1'b0;
            RdEn       <= 1'b0;
            Address    <= '0;
            WrData     <= '0;
            ALU_EN     <= 1'b0;
            ALU_FUNC   <= '0;
            CLK_EN     <= 1'b0;
            clk_div_en <= 1'b1;
            TX_P_DATA  <= '0;
            TX_D_VLD   <= 1'b0;
            CMD_ERR    <= 1'b0;
        end else begin
            state      <= state_d;
            addr_lat   <= addr_lat_d;
            tx_buf     <= tx_buf_d;
            tx_cnt     <= tx_cnt_d;
            WrEn       <= wr_en_d;
            RdEn       <= rd_en_d;
            Address    <= address_d;
            WrData     <= wr_data_d;
            ALU_EN     <= alu_en_d;
            ALU_FUNC   <= alu_func_d;
            CLK_EN     <= clk_en_d;
            clk_div_en <= 1'b1;
            TX_P_DATA  <= tx_data_d;
            TX_D_VLD   <= tx_vld_d;
            CMD_ERR    <= cmd_err_d;
        end
    end

endmodule

// File: tb/tb_sys_cmd_ctrl.sv
// Directed self-checking bench for sys_cmd_ctrl; with SYS_CMD_CTRL_TIMEOUT_EN it also exercises the timeout.
module tb_sys_cmd_ctrl;

    localparam int TIMEOUT_CYC = 1024;

    logic        CLK = 1'b0;
    logic        RST;
    logic [7:0]  RX_P_DATA;
    logic        RX_D_VLD;
    logic [7:0]  RD_DATA;
    logic        RD_DATA_VALID;
    logic [15:0] ALU_OUT;
    logic        OUT_VALID;
    logic        FIFO_FULL;
    logic        WrEn, RdEn, ALU_EN, CLK_EN, clk_div_en, TX_D_VLD, CMD_ERR;
    logic [3:0]  Address, ALU_FUNC;
    logic [7:0]  WrData, TX_P_DATA;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  tx_q[$];
    int          wr_count;
    int          err_count;

    sys_cmd_ctrl #(.TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .CLK(CLK), .RST(RST),
        .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .RD_DATA(RD_DATA), .RD_DATA_VALID(RD_DATA_VALID),
        .ALU_OUT(ALU_OUT), .OUT_VALID(OUT_VALID), .FIFO_FULL(FIFO_FULL),
        .WrEn(WrEn), .RdEn(RdEn), .Address(Address), .WrData(WrData),
        .ALU_EN(ALU_EN), .ALU_FUNC(ALU_FUNC), .CLK_EN(CLK_EN), .clk_div_en(clk_div_en),
        .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .CMD_ERR(CMD_ERR)
    );

    always #5 CLK = ~CLK;

    // Record every strobe once per cycle, away from the active edge.
    always @(negedge CLK) begin
        if (TX_D_VLD) tx_q.push_back(TX_P_DATA);
        if (WrEn)     wr_count++;
        if (CMD_ERR)  err_count++;
    end

    task automatic clear_monitors();
        tx_q.delete();
        wr_count  = 0;
        err_count = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge CLK);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        @(posedge CLK);
        #1;
        RX_D_VLD  = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b0; RX_P_DATA = '0; RX_D_VLD = 0; RD_DATA = '0; RD_DATA_VALID = 0;
        ALU_OUT = '0; OUT_VALID = 0; FIFO_FULL = 0;
        repeat (3) @(posedge CLK);
        #1;
        n_checks++;
        if ({WrEn, RdEn, ALU_EN, CLK_EN, TX_D_VLD, CMD_ERR} !== 6'b0) begin
            n_fail++; $display("[TB] FAIL reset_strobes: got %b expected 000000", {WrEn, RdEn, ALU_EN, CLK_EN, TX_D_VLD, CMD_ERR});
        end
        n_checks++;
        if ({Address, WrData, ALU_FUNC, TX_P_DATA} !== 24'h0) begin
            n_fail++; $display("[TB] FAIL reset_data: got %h expected 000000", {Address, WrData, ALU_FUNC, TX_P_DATA});
        end
        n_checks++;
        if (clk_div_en !== 1'b1) begin
            n_fail++; $display("[TB] FAIL reset_clk_div_en: got %b expected 1", clk_div_en);
        end
        @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(posedge CLK);
    endtask

    task automatic test_write();
        clear_monitors();
        send_byte(8'hAA);
        send_byte(8'h05);
        n_checks++;
        if (WrEn !== 1'b0) begin
            n_fail++; $display("[TB] FAIL wr_early: got %b expected 0", WrEn);
        end
        send_byte(8'h3C);
        n_checks++;
        if ({WrEn, Address, WrData} !== {1'b1, 4'h5, 8'h3C}) begin
            n_fail++; $display("[TB] FAIL wr_strobe: got en=%b addr=%h data=%h expected en=1 addr=5 data=3c", WrEn, Address, WrData);
        end
        @(posedge CLK); #1;
        n_checks++;
        if ({WrEn, Address, WrData} !== {1'b0, 4'h5, 8'h3C}) begin
            n_fail++; $display("[TB] FAIL wr_hold: got en=%b addr=%h data=%h expected en=0 addr=5 data=3c", WrEn, Address, WrData);
        end
        repeat (3) @(negedge CLK);
        n_checks++;
        if (wr_count != 1 || tx_q.size() != 0) begin
            n_fail++; $display("[TB] FAIL wr_counts: got wr=%0d tx=%0d expected wr=1 tx=0", wr_count, tx_q.size());
        end
    endtask

    task automatic test_read();
        clear_monitors();
        send_byte(8'hBB);
        send_byte(8'h02);
        n_checks++;
        if ({RdEn, Address} !== {1'b1, 4'h2}) begin
            n_fail++; $display("[TB] FAIL rd_strobe: got en=%b addr=%h expected en=1 addr=2", RdEn, Address);
        end
        send_byte(8'hAA);
        n_checks++;
        if (RdEn !== 1'b0) begin
            n_fail++; $display("[TB] FAIL rd_pulse_len: got %b expected 0", RdEn);
        end
        @(negedge CLK);
        RD_DATA = 8'h7E; RD_DATA_VALID = 1'b1;
        @(posedge CLK); #1;
        RD_DATA_VALID = 1'b0;
        n_checks++;
        if (TX_D_VLD !== 1'b0) begin
            n_fail++; $display("[TB] FAIL rd_tx_latency: got %b expected 0", TX_D_VLD);
        end
        @(posedge CLK); #1;
        n_checks++;
        if ({TX_D_VLD, TX_P_DATA} !== {1'b1, 8'h7E}) begin
            n_fail++; $display("[TB] FAIL rd_tx_byte: got vld=%b data=%h expected vld=1 data=7e", TX_D_VLD, TX_P_DATA);
        end
        repeat (4) @(negedge CLK);
        n_checks++;
        if (tx_q.size() != 1 || wr_count != 0) begin
            n_fail++; $display("[TB] FAIL rd_counts: got tx=%0d wr=%0d expected tx=1 wr=0", tx_q.size(), wr_count);
        end
    endtask

    task automatic test_alu_op();
        clear_monitors();
        send_byte(8'hCC);
        send_byte(8'h10);
        n_checks++;
        if ({WrEn, Address, WrData, CLK_EN} !== {1'b1, 4'h0, 8'h10, 1'b0}) begin
            n_fail++; $display("[TB] FAIL alu_wr_a: got en=%b addr=%h data=%h clk_en=%b expected 1/0/10/0", WrEn, Address, WrData, CLK_EN);
        end
        send_byte(8'h20);
        n_checks++;
        if ({WrEn, Address, WrData, CLK_EN} !== {1'b1, 4'h1, 8'h20, 1'b0}) begin
            n_fail++; $display("[TB] FAIL alu_wr_b: got en=%b addr=%h data=%h clk_en=%b expected 1/1/20/0", WrEn, Address, WrData, CLK_EN);
        end
        send_byte(8'h01);
        n_checks++;
        if ({ALU_FUNC, ALU_EN, CLK_EN, WrEn} !== {4'h1, 1'b1, 1'b1, 1'b0}) begin
            n_fail++; $display("[TB] FAIL alu_fn: got func=%h en=%b clk_en=%b wr=%b expected 1/1/1/0", ALU_FUNC, ALU_EN, CLK_EN, WrEn);
        end
        repeat (3) @(posedge CLK);
        #1;
        n_checks++;
        if ({ALU_EN, CLK_EN} !== 2'b11) begin
            n_fail++; $display("[TB] FAIL alu_wait_hold: got en=%b clk_en=%b expected 11", ALU_EN, CLK_EN);
        end
        @(negedge CLK);
        ALU_OUT = 16'h1234; OUT_VALID = 1'b1;
        @(posedge CLK); #1;
        OUT_VALID = 1'b0;
        n_checks++;
        if ({ALU_EN, CLK_EN, ALU_FUNC} !== {2'b00, 4'h1}) begin
            n_fail++; $display("[TB] FAIL alu_done: got en=%b clk_en=%b func=%h expected 0/0/1", ALU_EN, CLK_EN, ALU_FUNC);
        end
        repeat (5) @(negedge CLK);
        n_checks++;
        if (tx_q.size() != 2 || wr_count != 2) begin
            n_fail++; $display("[TB] FAIL alu_counts: got tx=%0d wr=%0d expected tx=2 wr=2", tx_q.size(), wr_count);
        end else begin
            n_checks++;
            if ({tx_q[0], tx_q[1]} !== 16'h3412) begin
                n_fail++; $display("[TB] FAIL alu_tx_order: got %h %h expected 34 12", tx_q[0], tx_q[1]);
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_monitors();
        send_byte(8'hDD);
        send_byte(8'h00);
        n_checks++;
        if ({ALU_FUNC, ALU_EN, CLK_EN, WrEn} !== {4'h0, 3'b110}) begin
            n_fail++; $display("[TB] FAIL nop_fn: got func=%h en=%b clk_en=%b wr=%b expected 0/1/1/0", ALU_FUNC, ALU_EN, CLK_EN, WrEn);
        end
        @(negedge CLK);
        FIFO_FULL = 1'b1; ALU_OUT = 16'hA5C3; OUT_VALID = 1'b1;
        @(posedge CLK); #1;
        OUT_VALID = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK); #1;
            n_checks++;
            if (TX_D_VLD !== 1'b0) begin
                n_fail++; $display("[TB] FAIL full_hold_%0d: got vld=%b expected 0", i, TX_D_VLD);
            end
        end
        @(negedge CLK);
        FIFO_FULL = 1'b0;
        @(posedge CLK); #1;
        n_checks++;
        if ({TX_D_VLD, TX_P_DATA} !== {1'b1, 8'hC3}) begin
            n_fail++; $display("[TB] FAIL bp_first: got vld=%b data=%h expected vld=1 data=c3", TX_D_VLD, TX_P_DATA);
        end
        @(negedge CLK);
        FIFO_FULL = 1'b1;
        repeat (3) @(negedge CLK);
        n_checks++;
        if (tx_q.size() != 1) begin
            n_fail++; $display("[TB] FAIL bp_stall: got tx=%0d expected 1", tx_q.size());
        end
        FIFO_FULL = 1'b0;
        repeat (3) @(negedge CLK);
        n_checks++;
        if (tx_q.size() != 2) begin
            n_fail++; $display("[TB] FAIL bp_count: got tx=%0d expected 2", tx_q.size());
        end else begin
            n_checks++;
            if ({tx_q[0], tx_q[1]} !== 16'hC3A5) begin
                n_fail++; $display("[TB] FAIL bp_order: got %h %h expected c3 a5", tx_q[0], tx_q[1]);
            end
        end
    endtask

    task automatic test_bad_opcode();
        clear_monitors();
        send_byte(8'h55);
        n_checks++;
        if (CMD_ERR !== 1'b1) begin
            n_fail++; $display("[TB] FAIL err_pulse: got %b expected 1", CMD_ERR);
        end
        @(posedge CLK); #1;
        n_checks++;
        if (CMD_ERR !== 1'b0) begin
            n_fail++; $display("[TB] FAIL err_len: got %b expected 0", CMD_ERR);
        end
        send_byte(8'hAA);
        send_byte(8'h03);
        send_byte(8'h44);
        n_checks++;
        if ({WrEn, Address, WrData, err_count[3:0]} !== {1'b1, 4'h3, 8'h44, 4'd1}) begin
            n_fail++; $display("[TB] FAIL err_then_idle: got en=%b addr=%h data=%h errs=%0d expected 1/3/44/1", WrEn, Address, WrData, err_count);
        end
    endtask

    task automatic test_reset_mid();
        clear_monitors();
        send_byte(8'hCC);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h07);
        n_checks++;
        if (CLK_EN !== 1'b1) begin
            n_fail++; $display("[TB] FAIL pre_reset_clk_en: got %b expected 1", CLK_EN);
        end
        @(negedge CLK);
        RST = 1'b0;
        #1;
        n_checks++;
        if ({WrEn, RdEn, ALU_EN, CLK_EN, TX_D_VLD, CMD_ERR, clk_div_en} !== 7'b0000001 ||
            {Address, WrData, ALU_FUNC, TX_P_DATA} !== 24'h0) begin
            n_fail++; $display("[TB] FAIL mid_reset: got ctl=%b data=%h expected ctl=0000001 data=000000",
                               {WrEn, RdEn, ALU_EN, CLK_EN, TX_D_VLD, CMD_ERR, clk_div_en},
                               {Address, WrData, ALU_FUNC, TX_P_DATA});
        end
        @(negedge CLK);
        RST = 1'b1;
        ALU_OUT = 16'hBEEF; OUT_VALID = 1'b1;
        @(negedge CLK);
        OUT_VALID = 1'b0;
        repeat (4) @(negedge CLK);
        n_checks++;
        if (tx_q.size() != 0 || CLK_EN !== 1'b0) begin
            n_fail++; $display("[TB] FAIL post_reset_idle: got tx=%0d clk_en=%b expected tx=0 clk_en=0", tx_q.size(), CLK_EN);
        end
    endtask

`ifdef SYS_CMD_CTRL_TIMEOUT_EN
    task automatic test_timeout();
        clear_monitors();
        send_byte(8'hAA);
        repeat (TIMEOUT_CYC + 5) @(negedge CLK);
        n_checks++;
        if (err_count != 1 || wr_count != 0) begin
            n_fail++; $display("[TB] FAIL timeout_err: got errs=%0d wr=%0d expected errs=1 wr=0", err_count, wr_count);
        end
        send_byte(8'hAA);
        send_byte(8'h06);
        send_byte(8'h99);
        n_checks++;
        if ({WrEn, Address, WrData} !== {1'b1, 4'h6, 8'h99}) begin
            n_fail++; $display("[TB] FAIL timeout_idle: got en=%b addr=%h data=%h expected 1/6/99", WrEn, Address, WrData);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_read();
        test_alu_op();
        test_back_to_back();
        test_bad_opcode();
        test_reset_mid();
`ifdef SYS_CMD_CTRL_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
